// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 status codes, icodes and register IDs
package y86_pkg;
    localparam int WIDTH = 64;
    localparam int NREGS = 15;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] INOP = 4'h1;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_exception(input logic [2:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction
endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 15x64 register file, two combinational reads, two writes with M-port priority
module regfile
    import y86_pkg::*;
#(
    parameter int W = WIDTH,
    parameter int N = NREGS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   src_a,
    input  logic [3:0]   src_b,
    output logic [W-1:0] rval_a,
    output logic [W-1:0] rval_b,
    input  logic [3:0]   dst_e,
    input  logic [W-1:0] val_e,
    input  logic         we_e,
    input  logic [3:0]   dst_m,
    input  logic [W-1:0] val_m,
    input  logic         we_m
);
    logic [W-1:0] regs [N];

    // M write comes second so it overrides E on a shared destination (popq %rsp)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else begin
            if (we_e && (dst_e < 4'(N))) regs[dst_e] <= val_e;
            if (we_m && (dst_m < 4'(N))) regs[dst_m] <= val_m;
        end
    end

    assign rval_a = (src_a < 4'(N)) ? regs[src_a] : '0;
    assign rval_b = (src_b < 4'(N)) ? regs[src_b] : '0;
endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 writeback: W pipeline register, commit gating, halt tracking
module writeback_stage
    import y86_pkg::*;
#(
    parameter int WIDTH = y86_pkg::WIDTH,
    parameter int NREGS = y86_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [WIDTH-1:0] m_valE,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic             W_stall,
    input  logic             W_bubble,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [WIDTH-1:0] d_rvalA,
    output logic [WIDTH-1:0] d_rvalB,
    output logic [2:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [WIDTH-1:0] W_valE,
    output logic [WIDTH-1:0] W_valM,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [2:0]       Stat,
    output logic             halted
);
    logic commit_ok;
    logic we_e;
    logic we_m;

    // Stall outranks bubble so a held instruction is never lost
    always_ff @(posedge clk) begin
        if (rst || (!W_stall && W_bubble)) begin
            W_stat  <= SBUB;
            W_icode <= INOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (!W_stall) begin
            W_stat  <= m_stat;
            W_icode <= m_icode;
            W_valE  <= m_valE;
            W_valM  <= m_valM;
            W_dstE  <= m_dstE;
            W_dstM  <= m_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (is_exception(W_stat)) begin
            halted <= 1'b1;
        end
    end

    assign commit_ok = (W_stat == SAOK) && !halted;
    assign we_e      = commit_ok && (W_dstE != RNONE);
    assign we_m      = commit_ok && (W_dstM != RNONE);
    assign Stat      = (W_stat == SBUB) ? SAOK : W_stat;

    regfile #(.W(WIDTH), .N(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB),
        .dst_e  (W_dstE),
        .val_e  (W_valE),
        .we_e   (we_e),
        .dst_m  (W_dstM),
        .val_m  (W_valM),
        .we_m   (we_m)
    );
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the Y86-64 pipelined processor, directly downstream of the memory stage. It holds the M→W pipeline register and the 15-entry 64-bit register file. Each cycle it commits `valE` and `valM` to their destination registers and reports the architectural status. It also serves the decode stage's two combinational register read ports, and exposes the W-register fields for decode-stage forwarding.

## Interface
- `WIDTH`, 64: data word width.
- `NREGS`, 15: architectural registers, IDs 0x0–0xE; 0xF = `RNONE`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `m_stat`  in  3  status from memory stage.
- `m_icode`  in  4  instruction code from memory stage.
- `m_valE`  in  64  ALU result.
- `m_valM`  in  64  data-memory read value.
- `m_dstE`  in  4  destination for `valE`.
- `m_dstM`  in  4  destination for `valM`.
- `W_stall`  in  1  hold W register.
- `W_bubble`  in  1  load nop bubble into W register.
- `d_srcA`, `d_srcB`  in  4 each  decode read addresses.
- `d_rvalA`, `d_rvalB`  out  64 each  register read data.
- `W_stat`, `W_icode`, `W_valE`, `W_valM`, `W_dstE`, `W_dstM`  out  3/4/64/64/4/4  W register contents, used for forwarding.
- `Stat`  out  3  architectural status.
- `halted`  out  1  sticky: the pipeline has retired a non-AOK instruction.

## Operation
- Status codes: `SBUB`=0, `SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4. Icode `INOP`=1.
- W register update on each rising edge, in priority order:
  - `rst`: load the bubble.
  - else `W_stall`: hold. Stall wins if both `W_stall` and `W_bubble` are high.
  - else `W_bubble`: load the bubble.
  - else: load the `m_*` inputs.
- Bubble value: stat=`SBUB`, icode=`INOP`, valE=valM=0, dstE=dstM=`RNONE`.
- Write enable per port: `W_stat==SAOK` && `!halted` && dst≠`RNONE`.
  - Writes commit on the rising edge from the current W contents.
  - If dstE==dstM and both ports are enabled, the M port wins (popq %rsp semantics).
- `halted` sets at an edge when `W_stat` ∈ {SHLT, SADR, SINS}. It clears only on `rst`.
  - The excepting instruction itself performs no write.
- `Stat` is combinational: `SAOK` when `W_stat==SBUB`, else `W_stat`.
- Read ports are combinational: `d_rvalX = regs[d_srcX]`; `RNONE` reads 0.
  - No internal write-to-read bypass; decode forwards from the `W_*` outputs.
- Any m-stage stat or dst values outside the defined set pass through unchanged. Writes are still gated as above.

## Timing
- Reset values:
  - all registers 0.
  - W register = bubble.
  - `halted`=0, so `Stat`=`SAOK`.
  - `d_rvalA/B`=0.
- Latency:
  - An instruction presented at `m_*` in cycle t is in `W_*` during cycle t+1.
  - Its writes commit at the end of cycle t+1.
  - The new value is visible on `d_rvalX` in cycle t+2.
- Stalled cycles re-present the same W contents; the rewrite is idempotent.
- Reset asserted mid-operation clears everything at the next edge. Pending writes in the W register at that edge are discarded, because reset has priority.
- After `halted` sets, register-file contents are frozen. `W_*` outputs still follow the stall/bubble rules.

## Structure
- Shared package `y86_pkg`:
  - stat codes.
  - icodes.
  - `RNONE`, `RRSP`.
  - `WIDTH`.
- Sub-module `regfile`: 15×64 array with two read ports, two write ports (M priority) and synchronous reset.
- The top level holds the W register, the write-enable logic and `halted`.

## Test plan
- Reset: assert `rst` for one edge → all 15 registers read 0, `W_icode`=1, `W_dstE`=0xF, `Stat`=1, `halted`=0.
- irmovq: `m_stat`=1, `m_icode`=3, `m_dstE`=3, `m_valE`=0x1234, `m_dstM`=F → `W_valE`=0x1234 the next cycle; `d_srcA`=3 reads 0x1234 one cycle after that; `d_srcB`=F reads 0.
- popq %rsp: dstE=4 with valE=0x100, dstM=4 with valM=0x55 → `regs[4]`=0x55.
- Exception: mrmovq with `m_stat`=3, dstM=2, valM=0xAA → `regs[2]` unchanged, `Stat`=3, `halted`=1. A following AOK irmovq to r5 leaves r5 at 0.
- Stall/bubble:
  - `W_stall` for 2 cycles → `W_*` held.
  - `W_bubble` → W becomes the bubble, no writes, `Stat`=1.
  - Stall and bubble together → behaves as stall.
- Reset mid-operation: r1=0x77 written, then `rst` asserted while W holds a write to r6 → r1=0, r6=0, W=bubble.
